// File: rtl/grant_sequencer.sv
// Grant sequencer: turns a one-hot arbiter grant into a locked bus tenure
// with a per-master burst length, ready/valid beats, stall timeout and withdrawal abort.
module grant_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       grant_in,
  input  logic [3:0]       req,
  input  logic [LEN_W-1:0] len_0,
  input  logic [LEN_W-1:0] len_1,
  input  logic [LEN_W-1:0] len_2,
  input  logic [LEN_W-1:0] len_3,
  input  logic             bus_ready,
  output logic [3:0]       owner,
  output logic             bus_valid,
  output logic [LEN_W-1:0] beat_cnt,
  output logic [3:0]       done,
  output logic             timeout_err,
  output logic             grant_err,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StLock, StXfer, StRelease} state_e;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [3:0]       owner_q, owner_d;
  logic             bus_valid_q, bus_valid_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [3:0]       done_q, done_d;
  logic             timeout_err_q, timeout_err_d;
  logic             grant_err_q, grant_err_d;
  logic             busy_q, busy_d;
  logic [7:0]       stall_q, stall_d;
  logic [LEN_W-1:0] len_q, len_d;

  logic [LEN_W-1:0] len_sel;
  logic             grant_onehot, grant_ok;
  logic             last_beat, stall_hit, withdrawn;
  logic [7:0]       stall_inc;

  always_comb begin
    unique case (grant_in)
      4'b0001: len_sel = len_0;
      4'b0010: len_sel = len_1;
      4'b0100: len_sel = len_2;
      4'b1000: len_sel = len_3;
      default: len_sel = '0;
    endcase
  end

  assign grant_onehot = (grant_in != 4'b0) && ((grant_in & (grant_in - 4'd1)) == 4'b0);
  assign grant_ok     = grant_onehot && ((grant_in & req) != 4'b0);
  // len_q is at least 1 whenever a tenure is active, so len_q-1 cannot underflow.
  assign last_beat    = bus_ready && (beat_cnt_q == (len_q - LEN_W'(1)));
  assign stall_inc    = (stall_q == TimeoutVal) ? stall_q : stall_q + 8'd1;
  assign stall_hit    = !bus_ready && (stall_inc == TimeoutVal);
  assign withdrawn    = (req & owner_q) == 4'b0;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    bus_valid_d   = bus_valid_q;
    beat_cnt_d    = beat_cnt_q;
    done_d        = 4'b0;
    timeout_err_d = 1'b0;
    grant_err_d   = 1'b0;
    busy_d        = busy_q;
    stall_d       = stall_q;
    len_d         = len_q;

    unique case (state_q)
      StIdle: begin
        if (grant_ok) begin
          state_d    = StLock;
          owner_d    = grant_in;
          len_d      = (len_sel == '0) ? LEN_W'(1) : len_sel;
          busy_d     = 1'b1;
          beat_cnt_d = '0;
          stall_d    = 8'd0;
        end else if (grant_in != 4'b0) begin
          // Suppress back-to-back pulses while a bad grant is held.
          grant_err_d = !grant_err_q;
        end
      end
      StLock: begin
        state_d     = StXfer;
        bus_valid_d = 1'b1;
      end
      StXfer: begin
        if (last_beat || stall_hit || withdrawn) begin
          state_d     = StRelease;
          owner_d     = 4'b0;
          bus_valid_d = 1'b0;
          beat_cnt_d  = '0;
          stall_d     = 8'd0;
          if (last_beat) begin
            done_d = owner_q;
          end else if (stall_hit) begin
            timeout_err_d = 1'b1;
          end
        end else if (bus_ready) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          stall_d    = 8'd0;
        end else begin
          stall_d = stall_inc;
        end
      end
      StRelease: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      owner_q       <= 4'b0;
      bus_valid_q   <= 1'b0;
      beat_cnt_q    <= '0;
      done_q        <= 4'b0;
      timeout_err_q <= 1'b0;
      grant_err_q   <= 1'b0;
      busy_q        <= 1'b0;
      stall_q       <= 8'd0;
      len_q         <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      bus_valid_q   <= bus_valid_d;
      beat_cnt_q    <= beat_cnt_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      grant_err_q   <= grant_err_d;
      busy_q        <= busy_d;
      stall_q       <= stall_d;
      len_q         <= len_d;
    end
  end

  assign owner       = owner_q;
  assign bus_valid   = bus_valid_q;
  assign beat_cnt    = beat_cnt_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign grant_err   = grant_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_grant_sequencer.sv
// Bench for grant_sequencer: directed scenarios plus randomized traffic checked
// against a cycle-level reference model derived from the observable tenure rules.
module tb_grant_sequencer;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned LEN_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       grant_in = 4'b0;
  logic [3:0]       req = 4'b0;
  logic [LEN_W-1:0] len_0 = '0;
  logic [LEN_W-1:0] len_1 = '0;
  logic [LEN_W-1:0] len_2 = '0;
  logic [LEN_W-1:0] len_3 = '0;
  logic             bus_ready = 1'b0;
  logic [3:0]       owner;
  logic             bus_valid;
  logic [LEN_W-1:0] beat_cnt;
  logic [3:0]       done;
  logic             timeout_err;
  logic             grant_err;
  logic             busy;

  logic [15:0] obs;
  int tests = 0;
  int fails = 0;

  grant_sequencer #(
    .TIMEOUT(TIMEOUT),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .grant_in   (grant_in),
    .req        (req),
    .len_0      (len_0),
    .len_1      (len_1),
    .len_2      (len_2),
    .len_3      (len_3),
    .bus_ready  (bus_ready),
    .owner      (owner),
    .bus_valid  (bus_valid),
    .beat_cnt   (beat_cnt),
    .done       (done),
    .timeout_err(timeout_err),
    .grant_err  (grant_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Layout: owner, bus_valid, beat_cnt, done, timeout_err, grant_err, busy
  assign obs = {owner, bus_valid, beat_cnt, done, timeout_err, grant_err, busy};

  function automatic logic [15:0] ev(int o, int v, int b, int d, int t, int g, int bz);
    return {o[3:0], v[0], b[3:0], d[3:0], t[0], g[0], bz[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (obs !== 16'h0) begin
      fails++;
      $display("FAIL reset_values: got %h expected %h", obs, 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    tests++;
    if (obs !== 16'h0) begin
      fails++;
      $display("FAIL idle_after_reset: got %h expected %h", obs, 16'h0);
    end
  endtask

  task automatic test_basic_burst();
    logic [15:0] exp_seq [6];
    exp_seq = '{ev('b0100, 0, 0, 0, 0, 0, 1), ev('b0100, 1, 0, 0, 0, 0, 1),
                ev('b0100, 1, 1, 0, 0, 0, 1), ev('b0100, 1, 2, 0, 0, 0, 1),
                ev(0, 0, 0, 'b0100, 0, 0, 1), ev(0, 0, 0, 0, 0, 0, 0)};
    req = 4'b0100; len_2 = 4'd3; bus_ready = 1'b1; grant_in = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (obs !== exp_seq[i]) begin
        fails++;
        $display("FAIL basic_burst[%0d]: got %h expected %h", i, obs, exp_seq[i]);
      end
      if (i == 0) grant_in = 4'b0;
    end
    req = 4'b0;
  endtask

  task automatic test_zero_len_stall();
    logic [15:0] exp_seq [5];
    exp_seq = '{ev('b0001, 0, 0, 0, 0, 0, 1), ev('b0001, 1, 0, 0, 0, 0, 1),
                ev('b0001, 1, 0, 0, 0, 0, 1), ev(0, 0, 0, 'b0001, 0, 0, 1),
                ev(0, 0, 0, 0, 0, 0, 0)};
    req = 4'b0001; len_0 = 4'd0; bus_ready = 1'b1; grant_in = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (obs !== exp_seq[i]) begin
        fails++;
        $display("FAIL zero_len_stall[%0d]: got %h expected %h", i, obs, exp_seq[i]);
      end
      if (i == 0) begin
        grant_in = 4'b0;
        bus_ready = 1'b0;
      end
      if (i == 2) bus_ready = 1'b1;
    end
    req = 4'b0;
  endtask

  task automatic test_timeout();
    req = 4'b1000; len_3 = 4'd3; bus_ready = 1'b1; grant_in = 4'b1000;
    step();
    tests++;
    if (obs !== ev('b1000, 0, 0, 0, 0, 0, 1)) begin
      fails++;
      $display("FAIL timeout_lock: got %h expected %h", obs, ev('b1000, 0, 0, 0, 0, 0, 1));
    end
    grant_in = 4'b0; bus_ready = 1'b0;
    step();
    // 15 stalled cycles must not time out; a handshake then restarts the count.
    for (int k = 1; k <= 15; k++) begin
      step();
      tests++;
      if (obs !== ev('b1000, 1, 0, 0, 0, 0, 1)) begin
        fails++;
        $display("FAIL stall_a[%0d]: got %h expected %h", k, obs, ev('b1000, 1, 0, 0, 0, 0, 1));
      end
    end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      tests++;
      if (obs !== ev('b1000, 1, 1, 0, 0, 0, 1)) begin
        fails++;
        $display("FAIL stall_b[%0d]: got %h expected %h", k, obs, ev('b1000, 1, 1, 0, 0, 0, 1));
      end
    end
    step();
    tests++;
    if (obs !== ev(0, 0, 0, 0, 1, 0, 1)) begin
      fails++;
      $display("FAIL timeout_pulse: got %h expected %h", obs, ev(0, 0, 0, 0, 1, 0, 1));
    end
    step();
    tests++;
    if (obs !== 16'h0) begin
      fails++;
      $display("FAIL timeout_idle: got %h expected %h", obs, 16'h0);
    end
    req = 4'b0; bus_ready = 1'b1;
  endtask

  task automatic test_withdraw_race();
    logic [15:0] exp_a [5];
    logic [15:0] exp_b [4];
    exp_a = '{ev('b0010, 0, 0, 0, 0, 0, 1), ev('b0010, 1, 0, 0, 0, 0, 1),
              ev('b0010, 1, 1, 0, 0, 0, 1), ev(0, 0, 0, 'b0010, 0, 0, 1),
              ev(0, 0, 0, 0, 0, 0, 0)};
    exp_b = '{ev('b0010, 0, 0, 0, 0, 0, 1), ev('b0010, 1, 0, 0, 0, 0, 1),
              ev(0, 0, 0, 0, 0, 0, 1), ev(0, 0, 0, 0, 0, 0, 0)};
    req = 4'b0010; len_1 = 4'd2; bus_ready = 1'b1; grant_in = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (obs !== exp_a[i]) begin
        fails++;
        $display("FAIL race_complete[%0d]: got %h expected %h", i, obs, exp_a[i]);
      end
      if (i == 0) grant_in = 4'b0;
      if (i == 2) req = 4'b0;
    end
    req = 4'b0010; grant_in = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (obs !== exp_b[i]) begin
        fails++;
        $display("FAIL race_withdraw[%0d]: got %h expected %h", i, obs, exp_b[i]);
      end
      if (i == 0) grant_in = 4'b0;
      if (i == 1) req = 4'b0;
    end
  endtask

  task automatic test_grant_err();
    logic [15:0] exp_h [7];
    req = 4'b0110; grant_in = 4'b0110;
    step();
    tests++;
    if (obs !== ev(0, 0, 0, 0, 0, 1, 0)) begin
      fails++;
      $display("FAIL gerr_multi: got %h expected %h", obs, ev(0, 0, 0, 0, 0, 1, 0));
    end
    grant_in = 4'b0;
    step();
    req = 4'b0000; grant_in = 4'b0001;
    step();
    tests++;
    if (obs !== ev(0, 0, 0, 0, 0, 1, 0)) begin
      fails++;
      $display("FAIL gerr_noreq: got %h expected %h", obs, ev(0, 0, 0, 0, 0, 1, 0));
    end
    step();
    tests++;
    if (obs !== 16'h0) begin
      fails++;
      $display("FAIL gerr_no_repeat: got %h expected %h", obs, 16'h0);
    end
    grant_in = 4'b0;
    step();
    exp_h = '{ev('b0001, 0, 0, 0, 0, 0, 1), ev('b0001, 1, 0, 0, 0, 0, 1),
              ev('b0001, 1, 1, 0, 0, 0, 1), ev('b0001, 1, 2, 0, 0, 0, 1),
              ev('b0001, 1, 3, 0, 0, 0, 1), ev(0, 0, 0, 'b0001, 0, 0, 1),
              ev(0, 0, 0, 0, 0, 0, 0)};
    req = 4'b0001; len_0 = 4'd4; bus_ready = 1'b1; grant_in = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      step();
      tests++;
      if (obs !== exp_h[i]) begin
        fails++;
        $display("FAIL grant_hold[%0d]: got %h expected %h", i, obs, exp_h[i]);
      end
      if (i == 0) begin
        grant_in = 4'b1000;
        req = 4'b1001;
      end
      if (i == 4) grant_in = 4'b0;
    end
    req = 4'b0;
  endtask

  task automatic test_async_reset();
    logic [15:0] exp_n [4];
    req = 4'b0100; len_2 = 4'd5; bus_ready = 1'b1; grant_in = 4'b0100;
    step();
    grant_in = 4'b0;
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (obs !== ev('b0100, 1, 2, 0, 0, 0, 1)) begin
      fails++;
      $display("FAIL pre_reset_beat2: got %h expected %h", obs, ev('b0100, 1, 2, 0, 0, 0, 1));
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (obs !== 16'h0) begin
      fails++;
      $display("FAIL async_reset: got %h expected %h", obs, 16'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_n = '{ev('b0001, 0, 0, 0, 0, 0, 1), ev('b0001, 1, 0, 0, 0, 0, 1),
              ev(0, 0, 0, 'b0001, 0, 0, 1), ev(0, 0, 0, 0, 0, 0, 0)};
    req = 4'b0001; len_0 = 4'd1; grant_in = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (obs !== exp_n[i]) begin
        fails++;
        $display("FAIL post_reset[%0d]: got %h expected %h", i, obs, exp_n[i]);
      end
      if (i == 0) grant_in = 4'b0;
    end
    req = 4'b0;
  endtask

  // Reference model: the tenure phase is inferred from the expected outputs
  // themselves (free / granted-not-driving / driving / releasing).
  task automatic test_random();
    logic [3:0]       e_owner, n_owner, e_done, n_done;
    logic             e_valid, n_valid, e_to, n_to, e_gerr, n_gerr, e_busy, n_busy;
    logic [LEN_W-1:0] e_beat, n_beat;
    logic [LEN_W-1:0] lv [4];
    logic [15:0]      expv;
    int m_len, m_stall, pct, r;
    e_owner = 4'b0; e_done = 4'b0; e_valid = 1'b0; e_to = 1'b0; e_gerr = 1'b0;
    e_busy = 1'b0; e_beat = '0; m_len = 0; m_stall = 0; pct = 90;
    for (int c = 0; c < 3000; c++) begin
      if (c % 300 == 0) pct = ((c / 300) % 3 == 0) ? 90 : (((c / 300) % 3 == 1) ? 50 : 4);
      for (int i = 0; i < 4; i++) lv[i] = LEN_W'($urandom_range(0, 15));
      len_0 = lv[0]; len_1 = lv[1]; len_2 = lv[2]; len_3 = lv[3];
      r = int'($urandom_range(0, 9));
      if (r < 4) grant_in = 4'b0;
      else if (r < 8) grant_in = 4'b0001 << $urandom_range(0, 3);
      else grant_in = 4'($urandom_range(0, 15));
      req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) != 0) req = req | e_owner;
      bus_ready = int'($urandom_range(0, 99)) < pct;

      n_owner = 4'b0; n_done = 4'b0; n_valid = 1'b0; n_to = 1'b0; n_gerr = 1'b0;
      n_busy = 1'b0; n_beat = '0;
      if (e_busy && e_owner == 4'b0) begin
        m_stall = 0;
      end else if (e_owner != 4'b0 && !e_valid) begin
        n_owner = e_owner; n_valid = 1'b1; n_busy = 1'b1;
      end else if (e_valid) begin
        n_busy = 1'b1;
        if (bus_ready && int'(e_beat) == m_len - 1) begin
          n_done = e_owner; m_stall = 0;
        end else if (!bus_ready && m_stall + 1 >= int'(TIMEOUT)) begin
          n_to = 1'b1; m_stall = 0;
        end else if ((req & e_owner) == 4'b0) begin
          m_stall = 0;
        end else begin
          n_owner = e_owner; n_valid = 1'b1;
          n_beat  = bus_ready ? e_beat + LEN_W'(1) : e_beat;
          m_stall = bus_ready ? 0 : m_stall + 1;
        end
      end else begin
        if ($countones(grant_in) == 1 && (grant_in & req) != 4'b0) begin
          n_owner = grant_in; n_busy = 1'b1; m_stall = 0;
          for (int i = 0; i < 4; i++) if (grant_in[i]) m_len = (lv[i] == '0) ? 1 : int'(lv[i]);
        end else if (grant_in != 4'b0) begin
          n_gerr = !e_gerr;
        end
      end

      step();
      expv = {n_owner, n_valid, n_beat, n_done, n_to, n_gerr, n_busy};
      tests++;
      if (obs !== expv) begin
        fails++;
        $display("FAIL random[%0d]: got %h expected %h", c, obs, expv);
      end
      e_owner = n_owner; e_done = n_done; e_valid = n_valid; e_to = n_to;
      e_gerr = n_gerr; e_busy = n_busy; e_beat = n_beat;
    end
    grant_in = 4'b0; req = 4'b0;
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_zero_len_stall();
    test_timeout();
    test_withdraw_race();
    test_grant_err();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
